// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-stage handshake between the pipeline and its hazard controller.
// The pipeline drives the master side and the controller sits on the slave side.
interface pipe_hazard_ctrl_if #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int CNT_BITS            = 16
);
  logic                           d_valid;
  logic [REG_INDEX_BIT_WIDTH-1:0] d_sr1;
  logic [REG_INDEX_BIT_WIDTH-1:0] d_sr2;
  logic                           d_sr1_used;
  logic                           d_sr2_used;
  logic [REG_INDEX_BIT_WIDTH-1:0] d_dr;
  logic                           d_regwrite;
  logic                           d_is_load;
  logic                           d_redirect;

  logic                           issue;
  logic                           pc_wrt_en;
  logic                           squash_d;
  logic                           fwd_sel1;
  logic                           fwd_sel2;
  logic [CNT_BITS-1:0]            stall_count;
  logic [CNT_BITS-1:0]            flush_count;

  modport master (
    output d_valid, d_sr1, d_sr2, d_sr1_used, d_sr2_used,
           d_dr, d_regwrite, d_is_load, d_redirect,
    input  issue, pc_wrt_en, squash_d, fwd_sel1, fwd_sel2,
           stall_count, flush_count
  );

  modport slave (
    input  d_valid, d_sr1, d_sr2, d_sr1_used, d_sr2_used,
           d_dr, d_regwrite, d_is_load, d_redirect,
    output issue, pc_wrt_en, squash_d, fwd_sel1, fwd_sel2,
           stall_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a D/X -> M/WB pipeline: forwards ALU results, stalls on
// load-use, squashes wrong-path fetches after redirects, and counts both events.
module pipe_hazard_ctrl #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int FLUSH_CYCLES        = 1,
  parameter int CNT_BITS            = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int MAX_CYC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] STALL_INIT = CW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_e;

  state_e                         state_q;
  logic [CW-1:0]                  cnt_q;
  logic                           m_valid_q;
  logic [REG_INDEX_BIT_WIDTH-1:0] m_dr_q;
  logic                           m_regwrite_q;
  logic                           m_is_load_q;
  logic [CNT_BITS-1:0]            stall_cnt_q;
  logic [CNT_BITS-1:0]            flush_cnt_q;

  logic match1, match2, load_use;
  logic issue_c, pc_wrt_en_c, squash_d_c;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  always_comb begin
    match1   = m_valid_q & m_regwrite_q & hz.d_sr1_used & (hz.d_sr1 == m_dr_q);
    match2   = m_valid_q & m_regwrite_q & hz.d_sr2_used & (hz.d_sr2 == m_dr_q);
    load_use = hz.d_valid & (match1 | match2) & m_is_load_q;

    issue_c     = 1'b0;
    pc_wrt_en_c = 1'b0;
    squash_d_c  = 1'b0;
    case (state_q)
      RUN: begin
        issue_c     = hz.d_valid & ~load_use;
        pc_wrt_en_c = ~load_use;
        squash_d_c  = load_use;
      end
      // Held decode slot: neither advanced nor discarded.
      STALL: begin
        issue_c     = 1'b0;
        pc_wrt_en_c = 1'b0;
        squash_d_c  = 1'b0;
      end
      FLUSH: begin
        issue_c     = 1'b0;
        pc_wrt_en_c = 1'b1;
        squash_d_c  = 1'b1;
      end
      default: begin
        issue_c     = 1'b0;
        pc_wrt_en_c = 1'b0;
        squash_d_c  = 1'b0;
      end
    endcase
  end

  assign hz.issue       = issue_c;
  assign hz.pc_wrt_en   = pc_wrt_en_c;
  assign hz.squash_d    = squash_d_c;
  assign hz.fwd_sel1    = match1 & ~m_is_load_q;
  assign hz.fwd_sel2    = match2 & ~m_is_load_q;
  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      m_valid_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      m_valid_q <= issue_c;
      case (state_q)
        RUN: begin
          if (load_use) begin
            state_q     <= STALL;
            cnt_q       <= STALL_INIT;
            stall_cnt_q <= sat_inc(stall_cnt_q);
          end else if (issue_c && hz.d_redirect) begin
            state_q     <= FLUSH;
            cnt_q       <= FLUSH_INIT;
            flush_cnt_q <= sat_inc(flush_cnt_q);
          end
        end
        STALL, FLUSH: begin
          if (cnt_q == '0) state_q <= RUN;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Writer fields only matter while m_valid_q is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (issue_c) begin
      m_dr_q       <= hz.d_dr;
      m_regwrite_q <= hz.d_regwrite;
      m_is_load_q  <= hz.d_is_load;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations share stimulus and are tracked
// by a cycle-count reference model, plus fixed vectors and corner sequences.
module tb_pipe_hazard_ctrl;
  localparam int RW  = 4;
  localparam int A_L = 1, A_F = 1, A_C = 16;
  localparam int B_L = 3, B_F = 2, B_C = 2;

  logic clk   = 1'b0;
  logic rst_v = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_INDEX_BIT_WIDTH(RW), .CNT_BITS(A_C)) ifa ();
  pipe_hazard_ctrl_if #(.REG_INDEX_BIT_WIDTH(RW), .CNT_BITS(B_C)) ifb ();

  pipe_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(RW), .LOAD_STALL_CYCLES(A_L),
                     .FLUSH_CYCLES(A_F), .CNT_BITS(A_C))
    u_a (.clk(clk), .reset(rst_v), .hz(ifa));
  pipe_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(RW), .LOAD_STALL_CYCLES(B_L),
                     .FLUSH_CYCLES(B_F), .CNT_BITS(B_C))
    u_b (.clk(clk), .reset(rst_v), .hz(ifb));

  typedef struct {
    bit v; int s1; int s2; bit u1; bit u2; int dr; bit rw; bit ld; bit rd;
  } in_t;

  typedef struct {
    in_t x; bit [4:0] fl; int sc; int fc;
  } vec_t;

  // Model: cycles still to hold / squash, the in-flight writer, event totals.
  typedef struct {
    int hold; int kill; bit mv; int mdr; bit mrw; bit mld; int sc; int fc;
  } mdl_t;

  mdl_t ma, mb;
  in_t  prev_x;
  bit   prev_r = 1'b1;
  int   n_chk = 0, n_pass = 0;
  vec_t tbl[17];
  int   sat_exp[5] = '{1, 2, 3, 3, 3};

  function automatic in_t mk(bit v, int s1, int s2, bit u1, bit u2, int dr, bit rw, bit ld, bit rd);
    in_t x;
    x.v = v; x.s1 = s1; x.s2 = s2; x.u1 = u1; x.u2 = u2;
    x.dr = dr; x.rw = rw; x.ld = ld; x.rd = rd;
    return x;
  endfunction

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.hold = 0; m.kill = 0; m.mv = 0; m.mdr = 0; m.mrw = 0; m.mld = 0; m.sc = 0; m.fc = 0;
    return m;
  endfunction

  // Returns {issue, pc_wrt_en, squash_d, fwd_sel1, fwd_sel2}.
  function automatic bit [4:0] mdl_flags(mdl_t m, in_t x, output bit lu);
    bit h1, h2, iss, pc, sq;
    h1 = m.mv && m.mrw && x.u1 && (x.s1 == m.mdr);
    h2 = m.mv && m.mrw && x.u2 && (x.s2 == m.mdr);
    lu = 1'b0;
    if (m.hold > 0) begin
      iss = 0; pc = 0; sq = 0;
    end else if (m.kill > 0) begin
      iss = 0; pc = 1; sq = 1;
    end else begin
      lu  = x.v && (h1 || h2) && m.mld;
      iss = x.v && !lu;
      pc  = !lu;
      sq  = lu;
    end
    return {iss, pc, sq, h1 && !m.mld, h2 && !m.mld};
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, in_t x, int L, int F, int cmax);
    mdl_t n;
    bit lu;
    bit [4:0] f;
    n = m;
    f = mdl_flags(m, x, lu);
    if (m.hold > 0) n.hold = m.hold - 1;
    else if (m.kill > 0) n.kill = m.kill - 1;
    else if (lu) begin
      n.hold = L;
      n.sc   = (m.sc < cmax) ? m.sc + 1 : m.sc;
    end else if (f[4] && x.rd) begin
      n.kill = F;
      n.fc   = (m.fc < cmax) ? m.fc + 1 : m.fc;
    end
    n.mv = f[4];
    if (f[4]) begin
      n.mdr = x.dr; n.mrw = x.rw; n.mld = x.ld;
    end
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic apply(in_t x);
    ifa.d_valid = x.v; ifa.d_sr1 = RW'(x.s1); ifa.d_sr2 = RW'(x.s2);
    ifa.d_sr1_used = x.u1; ifa.d_sr2_used = x.u2; ifa.d_dr = RW'(x.dr);
    ifa.d_regwrite = x.rw; ifa.d_is_load = x.ld; ifa.d_redirect = x.rd;
    ifb.d_valid = x.v; ifb.d_sr1 = RW'(x.s1); ifb.d_sr2 = RW'(x.s2);
    ifb.d_sr1_used = x.u1; ifb.d_sr2_used = x.u2; ifb.d_dr = RW'(x.dr);
    ifb.d_regwrite = x.rw; ifb.d_is_load = x.ld; ifb.d_redirect = x.rd;
  endtask

  // One cycle: advance the model across the edge, then present x and compare.
  task automatic drive(in_t x, bit r);
    bit lu;
    @(posedge clk);
    if (prev_r) begin
      ma = mdl_rst();
      mb = mdl_rst();
    end else begin
      ma = mdl_step(ma, prev_x, A_L, A_F, (1 << A_C) - 1);
      mb = mdl_step(mb, prev_x, B_L, B_F, (1 << B_C) - 1);
    end
    @(negedge clk);
    apply(x);
    rst_v = r;
    #1;
    chk("mdl_a_flags", int'({ifa.issue, ifa.pc_wrt_en, ifa.squash_d, ifa.fwd_sel1, ifa.fwd_sel2}),
        int'(mdl_flags(ma, x, lu)));
    chk("mdl_a_stall", int'(ifa.stall_count), ma.sc);
    chk("mdl_a_flush", int'(ifa.flush_count), ma.fc);
    chk("mdl_b_flags", int'({ifb.issue, ifb.pc_wrt_en, ifb.squash_d, ifb.fwd_sel1, ifb.fwd_sel2}),
        int'(mdl_flags(mb, x, lu)));
    chk("mdl_b_stall", int'(ifb.stall_count), mb.sc);
    chk("mdl_b_flush", int'(ifb.flush_count), mb.fc);
    prev_x = x;
    prev_r = r;
  endtask

  task automatic exp_a(string nm, bit [4:0] fl, int sc, int fc);
    chk({nm, "_flags"}, int'({ifa.issue, ifa.pc_wrt_en, ifa.squash_d, ifa.fwd_sel1, ifa.fwd_sel2}), int'(fl));
    chk({nm, "_stall"}, int'(ifa.stall_count), sc);
    chk({nm, "_flush"}, int'(ifa.flush_count), fc);
  endtask

  task automatic exp_b(string nm, bit [4:0] fl, int sc, int fc);
    chk({nm, "_flags"}, int'({ifb.issue, ifb.pc_wrt_en, ifb.squash_d, ifb.fwd_sel1, ifb.fwd_sel2}), int'(fl));
    chk({nm, "_stall"}, int'(ifb.stall_count), sc);
    chk({nm, "_flush"}, int'(ifb.flush_count), fc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t z, lw5, add5, jal5, beq, beq_nr, x;

    z      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw5    = mk(1, 0, 0, 0, 0, 5, 1, 1, 0);
    add5   = mk(1, 7, 5, 1, 1, 6, 1, 0, 0);
    jal5   = mk(1, 5, 0, 1, 0, 1, 1, 0, 1);
    beq    = mk(1, 1, 2, 1, 1, 0, 0, 0, 1);
    beq_nr = mk(1, 1, 2, 1, 1, 0, 0, 0, 0);

    // Expected values for configuration A (one stall, one flush cycle).
    tbl[0]  = '{mk(1, 1, 2, 1, 1, 3, 1, 0, 0), 5'b11000, 0, 0};
    tbl[1]  = '{mk(1, 3, 5, 1, 1, 4, 1, 0, 0), 5'b11010, 0, 0};
    tbl[2]  = '{mk(1, 4, 0, 1, 0, 5, 1, 1, 0), 5'b11010, 0, 0};
    tbl[3]  = '{add5,                         5'b00100, 0, 0};
    tbl[4]  = '{add5,                         5'b00000, 1, 0};
    tbl[5]  = '{add5,                         5'b11000, 1, 0};
    tbl[6]  = '{mk(1, 6, 0, 1, 1, 0, 0, 0, 1), 5'b11010, 1, 0};
    tbl[7]  = '{mk(1, 6, 6, 1, 1, 9, 1, 0, 1), 5'b01100, 1, 1};
    tbl[8]  = '{z,                            5'b01000, 1, 1};
    tbl[9]  = '{mk(1, 1, 0, 1, 0, 0, 1, 0, 0), 5'b11000, 1, 1};
    tbl[10] = '{mk(1, 0, 0, 1, 1, 2, 1, 0, 0), 5'b11011, 1, 1};
    tbl[11] = '{mk(1, 2, 2, 0, 0, 7, 0, 0, 0), 5'b11000, 1, 1};
    tbl[12] = '{mk(1, 7, 0, 1, 0, 1, 1, 0, 0), 5'b11000, 1, 1};
    tbl[13] = '{mk(1, 0, 0, 0, 0, 8, 1, 1, 0), 5'b11000, 1, 1};
    tbl[14] = '{mk(0, 8, 8, 1, 1, 0, 0, 0, 0), 5'b01000, 1, 1};
    tbl[15] = '{mk(1, 8, 0, 1, 0, 3, 1, 0, 0), 5'b11000, 1, 1};
    tbl[16] = '{mk(0, 3, 3, 1, 1, 0, 0, 0, 0), 5'b01011, 1, 1};

    apply(z);
    drive(z, 1);
    drive(z, 0);
    exp_a("rst_a", 5'b01000, 0, 0);
    exp_b("rst_b", 5'b01000, 0, 0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].x, 0);
      exp_a($sformatf("tbl%0d", i), tbl[i].fl, tbl[i].sc, tbl[i].fc);
    end

    // Load-use and redirect on the same instruction (configuration A).
    drive(z, 1);
    drive(lw5, 0);  exp_a("lr_lw", 5'b11000, 0, 0);
    drive(jal5, 0); exp_a("lr_lu", 5'b00100, 0, 0);
    drive(jal5, 0); exp_a("lr_stall", 5'b00000, 1, 0);
    drive(jal5, 0); exp_a("lr_issue", 5'b11000, 1, 0);
    drive(z, 0);    exp_a("lr_flush", 5'b01100, 1, 1);
    drive(z, 0);    exp_a("lr_run", 5'b01000, 1, 1);

    // Two-cycle flush with a redirect arriving inside it (configuration B).
    drive(z, 1);
    drive(beq, 0);    exp_b("rd_issue", 5'b11000, 0, 0);
    drive(beq, 0);    exp_b("rd_fl1", 5'b01100, 0, 1);
    drive(beq, 0);    exp_b("rd_fl2", 5'b01100, 0, 1);
    drive(beq_nr, 0); exp_b("rd_run", 5'b11000, 0, 1);
    drive(z, 0);      exp_b("rd_after", 5'b01000, 0, 1);

    // Reset arriving on the second of three stall cycles (configuration B).
    drive(z, 1);
    drive(lw5, 0);  exp_b("rs_lw", 5'b11000, 0, 0);
    drive(add5, 0); exp_b("rs_lu", 5'b00100, 0, 0);
    drive(add5, 0); exp_b("rs_st1", 5'b00000, 1, 0);
    drive(add5, 1); exp_b("rs_st2", 5'b00000, 1, 0);
    drive(add5, 0); exp_b("rs_after", 5'b11000, 0, 0);

    // Two-bit stall counter saturates (configuration B).
    drive(z, 1);
    for (int k = 0; k < 5; k++) begin
      drive(lw5, 0);
      drive(add5, 0);
      for (int s = 0; s < 3; s++) drive(add5, 0);
      drive(add5, 0);
      exp_b($sformatf("sat%0d", k), 5'b11000, sat_exp[k], 0);
    end

    drive(z, 1);
    for (int n = 0; n < 1500; n++) begin
      x = mk($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0);
      drive(x, $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
